spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
Receive-side counterpart of the team's 12-bit SPI master transmitter. It oversamples sclk, cs and mosi in the system clk domain and assembles LSB-first frames into a parallel word. Each correctly framed transfer produces a one-cycle done strobe with the word; each malformed frame produces a one-cycle err strobe. It sits on the peripheral side of the link, feeding a register bank or FIFO.

Parameters:
WIDTH, 12, data bits per frame (LSB first).
SYNC_STAGES, 2, flip-flop synchronizer depth on each of sclk, cs and mosi (minimum 2).

Ports:
clk  input  1  system clock; must be at least 8x the sclk frequency (master runs sclk = clk/20).
rst  input  1  synchronous, active-high reset.
sclk  input  1  serial clock from master; asynchronous to clk.
cs  input  1  chip select from master, active low; asynchronous to clk.
mosi  input  1  serial data from master; master updates it on sclk rising edges.
dout  output  WIDTH  last correctly received word; held until the next done.
done  output  1  one-cycle pulse: dout has just been updated with a valid frame.
err  output  1  one-cycle pulse: frame aborted (short or long frame).
busy  output  1  high from the detected cs falling edge until frame end or error.

Behaviour:
- Synchronizers: sclk, cs and mosi each pass through SYNC_STAGES flops, so all three see identical latency. Call the outputs sclk_s, cs_s and mosi_s.
- Edge detect: register sclk_s and cs_s once more. fall_sclk = prev 1 & now 0. cs_fall and cs_rise are defined the same way on cs_s.
- Reset values:
  - dout = 0, done = 0, err = 0, busy = 0, state = ARM.
  - Sync and edge flops reset to the line idle levels: sclk 0, cs 1, mosi 0.
  - Bit counter = 0, shift register = 0.
- Sampling: mosi_s is sampled on fall_sclk only, which is the middle of each master bit. Bit k is written to shift[k], giving LSB first.
- State machine (one state register):
  - ARM: wait for cs_s == 1, then go to IDLE. This prevents reset or power-up in the middle of a frame from capturing a partial frame. No done or err is generated in ARM.
  - IDLE: on cs_fall, go to LEAD, busy <= 1, cnt <= 0.
  - LEAD: the master asserts cs one sclk period before driving bit 0, so the first fall_sclk after cs falls is discarded; on it go to SHIFT.
    - cs_rise in LEAD: err pulse, busy <= 0, go to IDLE.
  - SHIFT: on each fall_sclk, shift[cnt] <= mosi_s and cnt <= cnt + 1. When the WIDTH-th bit is captured (cnt == WIDTH-1 on that edge), go to WAIT_CS.
    - cs_rise in SHIFT (fewer than WIDTH bits): err pulse, busy <= 0, go to IDLE; dout unchanged.
  - WAIT_CS:
    - On cs_rise: dout <= shift, done <= 1 for exactly one clk, busy <= 0, go to IDLE.
    - Any fall_sclk before cs_rise (long frame): err pulse, go to ARM; dout unchanged and no done.
- Simultaneous fall_sclk and cs_rise in the same clk: cs_rise takes priority and the sclk edge is ignored.
- Latency: done is asserted in the clk cycle after the cycle in which cs_s is first seen high. That is SYNC_STAGES+1 clk cycles after cs rises at the pin, plus up to 1 cycle of synchronizer phase uncertainty.
- done and err are never high in the same cycle; each is high for at most one cycle per frame.
- cnt is wide enough for WIDTH; the counter never wraps, because WAIT_CS absorbs further edges.
- rst mid-frame: everything returns to reset values; the in-progress frame produces neither done nor err; the block re-arms only after cs is seen high.
- Back-to-back frames: a cs_fall arriving while cs_rise is being processed is accepted on the next cycle from IDLE. There is no minimum cs-high time beyond SYNC_STAGES+2 clk cycles.

Test Plan:
- Master sends 12'hA5C at clk/20 → exactly one done pulse; dout = 12'hA5C; err never high; busy high for the whole frame.
- Two back-to-back frames 12'h001 then 12'h800 (checks LSB/MSB ordering) → two done pulses; dout = 12'h001, then 12'h800.
- cs released after 5 data bits (prior dout = 12'h3C3) → one err pulse, no done; dout stays 12'h3C3; the following frame 12'h7E1 is received correctly.
- 13 sclk falling edges after the lead-in with cs low → err pulse, no done, state ARM; after cs high, frame 12'hFFF → dout = 12'hFFF.
- rst asserted for 3 clk cycles midway through frame 12'h555 while cs stays low → no done/err for that frame; all outputs 0 after reset; next frame 12'hAAA → dout = 12'hAAA.
- Hold cs low from reset with sclk toggling → no done/err until cs goes high; first full frame afterwards is received correctly.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: oversamples sclk/cs/mosi in clk and assembles LSB-first frames into dout.
// done follows cs_s high by one clk; no backpressure, dout is held until the next done.
module spi_slave_rx #(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    output logic             err,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int FW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [2:0] {ARM, IDLE, LEAD, SHIFT, WAIT_CS} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_d, cs_d;
    logic                   fall_sclk, cs_fall, cs_rise;
    logic [FW-1:0]          fill;
    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       shift;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign fall_sclk = sclk_d & ~sclk_s;
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    // The cs chain resets to idle-high, so ARM must not trust cs_s until the
    // chain has been refilled from the pin; otherwise a reset inside a frame
    // would arm straight away and capture the tail of that frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill <= '0;
        end else if (fill != FW'(SYNC_STAGES)) begin
            fill <= fill + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARM;
            cnt   <= '0;
            shift <= '0;
            dout  <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ARM: begin
                    if (fill == FW'(SYNC_STAGES) && cs_s) state <= IDLE;
                end
                IDLE: begin
                    if (cs_fall) begin
                        state <= LEAD;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                LEAD: begin
                    if (cs_rise) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (fall_sclk) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (fall_sclk) begin
                        shift[cnt[IW-1:0]] <= mosi_s;
                        cnt                <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) state <= WAIT_CS;
                    end
                end
                WAIT_CS: begin
                    if (cs_rise) begin
                        dout  <= shift;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (fall_sclk) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ARM;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed and random SPI master frames against a frame-level outcome model.
module tb_spi_slave_rx;
    localparam int WIDTH = 12;
    localparam int SYNC  = 2;
    localparam int HALF  = 10;

    logic             clk  = 1'b0;
    logic             rst  = 1'b1;
    logic             sclk = 1'b0;
    logic             cs   = 1'b1;
    logic             mosi = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             done;
    logic             err;
    logic             busy;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    bit both_seen = 1'b0;

    logic [WIDTH-1:0] exp_dout = '0;
    int exp_done = 0;
    int exp_err  = 0;
    int last_lat;
    bit busy_low;

    spi_slave_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .sclk(sclk),
        .cs  (cs),
        .mosi(mosi),
        .dout(dout),
        .done(done),
        .err (err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A frame is good only if exactly WIDTH bits follow the lead-in edge.
    task automatic model_frame(input logic [WIDTH-1:0] data, input int nbits);
        if (nbits == WIDTH) begin
            exp_done++;
            exp_dout = data;
        end else begin
            exp_err++;
        end
    endtask

    task automatic check_counts(input string tag);
        chk({tag, ".done_cnt"}, done_cnt, exp_done);
        chk({tag, ".err_cnt"}, err_cnt, exp_err);
        chk({tag, ".dout"}, 32'(dout), 32'(exp_dout));
    endtask

    task automatic half_period();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] data, input int nbits, input int rst_at);
        busy_low = 1'b0;
        last_lat = -1;
        @(negedge clk);
        cs = 1'b0;
        half_period(); sclk = 1'b1;
        half_period(); sclk = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            if (k == rst_at) begin
                rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                exp_dout = '0;
                chk("rst_mid.dout", 32'(dout), 0);
                chk("rst_mid.done", 32'(done), 0);
                chk("rst_mid.err", 32'(err), 0);
                chk("rst_mid.busy", 32'(busy), 0);
            end
            half_period();
            sclk = 1'b1;
            mosi = (k < WIDTH) ? data[k] : 1'($urandom);
            half_period();
            sclk = 1'b0;
            if (k < WIDTH && (rst_at < 0 || k < rst_at) && !busy) busy_low = 1'b1;
        end
        half_period();
        cs   = 1'b1;
        mosi = 1'b0;
        for (int i = 1; i <= 4 * SYNC + 8; i++) begin
            @(negedge clk);
            if (done && last_lat < 0) last_lat = i;
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [WIDTH-1:0] rdata;
        int nb;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        chk("reset.dout", 32'(dout), 0);
        chk("reset.done", 32'(done), 0);
        chk("reset.err", 32'(err), 0);
        chk("reset.busy", 32'(busy), 0);
        repeat (6) @(negedge clk);

        send_frame(12'hA5C, WIDTH, -1);
        model_frame(12'hA5C, WIDTH);
        check_counts("a5c");
        chk("a5c.latency", 32'(last_lat), SYNC + 1);
        chk("a5c.busy_low", 32'(busy_low), 0);

        send_frame(12'h001, WIDTH, -1);
        model_frame(12'h001, WIDTH);
        check_counts("b2b_001");
        chk("b2b_001.latency", 32'(last_lat), SYNC + 1);
        send_frame(12'h800, WIDTH, -1);
        model_frame(12'h800, WIDTH);
        check_counts("b2b_800");

        send_frame(12'h3C3, WIDTH, -1);
        model_frame(12'h3C3, WIDTH);
        check_counts("pre_short");
        send_frame(12'h0F0, 5, -1);
        model_frame(12'h0F0, 5);
        check_counts("short5");
        send_frame(12'h7E1, WIDTH, -1);
        model_frame(12'h7E1, WIDTH);
        check_counts("after_short");

        send_frame(12'h123, WIDTH + 1, -1);
        model_frame(12'h123, WIDTH + 1);
        check_counts("long13");
        chk("long13.busy", 32'(busy), 0);
        send_frame(12'hFFF, WIDTH, -1);
        model_frame(12'hFFF, WIDTH);
        check_counts("after_long");

        send_frame(12'h555, WIDTH, 6);
        check_counts("rst_mid_frame");
        send_frame(12'hAAA, WIDTH, -1);
        model_frame(12'hAAA, WIDTH);
        check_counts("after_rst");

        cs  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_dout = '0;
        for (int i = 0; i < 30; i++) begin
            half_period();
            sclk = ~sclk;
            mosi = 1'($urandom);
        end
        check_counts("cs_low_from_reset");
        cs = 1'b1;
        repeat (10) @(negedge clk);
        check_counts("cs_low_released");
        rdata = WIDTH'($urandom);
        send_frame(rdata, WIDTH, -1);
        model_frame(rdata, WIDTH);
        check_counts("cs_low_first_frame");

        for (int f = 0; f < 8; f++) begin
            rdata = WIDTH'($urandom);
            nb = ($urandom_range(0, 9) < 6) ? WIDTH : int'($urandom_range(0, WIDTH + 3));
            send_frame(rdata, nb, -1);
            model_frame(rdata, nb);
            check_counts("random");
        end

        chk("done_err_overlap", 32'(both_seen), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
